// File: rtl/tm_sr_dpr_rcv_if.sv
// Byte-stream and command/error bus between the slave byte decoder and
// the master-command receiver.
interface tm_sr_dpr_rcv_if;
  logic [7:0]  d;
  logic        d_rdy;
  logic        d_err;
  logic        tm_rcvd;
  logic        sr_rcvd;
  logic        dpr_rcvd;
  logic [15:0] payload;
  logic        msg_err;
  logic [1:0]  err_code;
  logic        busy;

  modport master (
    output d, d_rdy, d_err,
    input  tm_rcvd, sr_rcvd, dpr_rcvd, payload, msg_err, err_code, busy
  );

  modport slave (
    input  d, d_rdy, d_err,
    output tm_rcvd, sr_rcvd, dpr_rcvd, payload, msg_err, err_code, busy
  );
endinterface

// File: rtl/tm_sr_dpr_rcv.sv
// Frames and validates 5-byte master command messages (marker, flag,
// two payload bytes, checksum) and emits a one-cycle command pulse.
module tm_sr_dpr_rcv #(
  parameter logic [7:0] MARKER   = 8'hA5,
  parameter logic [7:0] FLAG_TM  = 8'h01,
  parameter logic [7:0] FLAG_SR  = 8'h02,
  parameter logic [7:0] FLAG_DPR = 8'h03,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  tm_sr_dpr_rcv_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLAG  = 3'd1;
  localparam logic [2:0] S_PL_HI = 3'd2;
  localparam logic [2:0] S_PL_LO = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  flag_q, flag_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] payload_q, payload_d;
  logic        tm_q, tm_d;
  logic        sr_q, sr_d;
  logic        dpr_q, dpr_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        busy;
  logic [7:0]  csum;

  assign busy = (state_q != S_IDLE);
  assign csum = flag_q + hi_q + lo_q;

  // Priority: decoder error, then byte strobe, then inter-byte timeout.
  always_comb begin
    state_d   = state_q;
    flag_d    = flag_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    payload_d = payload_q;
    code_d    = code_q;
    tm_d      = 1'b0;
    sr_d      = 1'b0;
    dpr_d     = 1'b0;
    err_d     = 1'b0;
    timer_d   = busy ? timer_q + 16'd1 : 16'd0;

    if (bus.d_err) begin
      if (busy) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        code_d  = 2'd3;
        timer_d = 16'd0;
      end
    end else if (bus.d_rdy) begin
      timer_d = 16'd0;
      case (state_q)
        S_IDLE: begin
          if (bus.d == MARKER) state_d = S_FLAG;
        end
        S_FLAG: begin
          if (bus.d == FLAG_TM || bus.d == FLAG_SR || bus.d == FLAG_DPR) begin
            flag_d  = bus.d;
            state_d = S_PL_HI;
          end else if (bus.d != MARKER) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = 2'd1;
          end
        end
        S_PL_HI: begin
          hi_d    = bus.d;
          state_d = S_PL_LO;
        end
        S_PL_LO: begin
          lo_d    = bus.d;
          state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_IDLE;
          if (bus.d == csum) begin
            payload_d = {hi_q, lo_q};
            tm_d      = (flag_q == FLAG_TM);
            sr_d      = (flag_q == FLAG_SR);
            dpr_d     = (flag_q == FLAG_DPR);
          end else begin
            err_d  = 1'b1;
            code_d = 2'd2;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (busy && timer_q == TMO_LAST) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      code_d  = 2'd3;
      timer_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      flag_q    <= 8'h00;
      hi_q      <= 8'h00;
      lo_q      <= 8'h00;
      timer_q   <= 16'd0;
      payload_q <= 16'h0000;
      tm_q      <= 1'b0;
      sr_q      <= 1'b0;
      dpr_q     <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      flag_q    <= flag_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      timer_q   <= timer_d;
      payload_q <= payload_d;
      tm_q      <= tm_d;
      sr_q      <= sr_d;
      dpr_q     <= dpr_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign bus.tm_rcvd  = tm_q;
  assign bus.sr_rcvd  = sr_q;
  assign bus.dpr_rcvd = dpr_q;
  assign bus.payload  = payload_q;
  assign bus.msg_err  = err_q;
  assign bus.err_code = code_q;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_tm_sr_dpr_rcv.sv
// Scoreboard bench for tm_sr_dpr_rcv: the driver queues the expected
// response to each deciding byte, a negedge monitor pops and compares.
module tb_tm_sr_dpr_rcv;

  localparam logic [7:0] MARKER   = 8'hA5;
  localparam logic [7:0] FLAG_TM  = 8'h01;
  localparam logic [7:0] FLAG_SR  = 8'h02;
  localparam logic [7:0] FLAG_DPR = 8'h03;
  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    logic [3:0]  pulses;
    logic [15:0] payload;
    logic [1:0]  code;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  tm_sr_dpr_rcv_if bus();

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [15:0] model_payload = 16'h0000;
  logic [1:0]  model_code = 2'd0;

  tm_sr_dpr_rcv #(
    .MARKER(MARKER), .FLAG_TM(FLAG_TM), .FLAG_SR(FLAG_SR),
    .FLAG_DPR(FLAG_DPR), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Called at a negedge; presents one byte/error strobe for exactly one cycle.
  task automatic applyStimulus(input logic [7:0] b, input logic rdy, input logic err);
    bus.d     = b;
    bus.d_rdy = rdy;
    bus.d_err = err;
    @(negedge clk);
    bus.d_rdy = 1'b0;
    bus.d_err = 1'b0;
  endtask

  task automatic expectCmd(input logic [7:0] flag, input logic [15:0] pl);
    exp_t e;
    model_payload = pl;
    e.pulses  = {flag == FLAG_TM, flag == FLAG_SR, flag == FLAG_DPR, 1'b0};
    e.payload = pl;
    e.code    = model_code;
    exp_q.push_back(e);
  endtask

  task automatic expectErr(input logic [1:0] code);
    exp_t e;
    model_code = code;
    e.pulses  = 4'b0001;
    e.payload = model_payload;
    e.code    = code;
    exp_q.push_back(e);
  endtask

  task automatic sendMsg(input logic [7:0] flag, input logic [7:0] hi,
                         input logic [7:0] lo, input logic [7:0] delta);
    logic [7:0] cs;
    cs = flag + hi + lo + delta;
    applyStimulus(MARKER, 1'b1, 1'b0);
    applyStimulus(flag, 1'b1, 1'b0);
    applyStimulus(hi, 1'b1, 1'b0);
    applyStimulus(lo, 1'b1, 1'b0);
    if (delta == 8'h00) expectCmd(flag, {hi, lo});
    else                expectErr(2'd2);
    applyStimulus(cs, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [3:0] act;
    exp_t e;
    act = {bus.tm_rcvd, bus.sr_rcvd, bus.dpr_rcvd, bus.msg_err};
    if (rst_n && act != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse: got %b expected none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e.pulses || bus.payload !== e.payload || bus.err_code !== e.code) begin
          errors++;
          $display("[TB] FAIL response: got pulses %b payload %h code %0d expected pulses %b payload %h code %0d",
                   act, bus.payload, bus.err_code, e.pulses, e.payload, e.code);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.d = 8'h00;
    bus.d_rdy = 1'b0;
    bus.d_err = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 16'(bus.busy), 16'd0);
    checkOutput("reset_pulses", 16'({bus.tm_rcvd, bus.sr_rcvd, bus.dpr_rcvd, bus.msg_err}), 16'd0);
    checkOutput("reset_payload", bus.payload, 16'h0000);
    checkOutput("reset_err_code", 16'(bus.err_code), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] garbage then valid time mark");
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b0);
    checkOutput("garbage_busy", 16'(bus.busy), 16'd0);
    applyStimulus(MARKER, 1'b1, 1'b0);
    checkOutput("marker_busy", 16'(bus.busy), 16'd1);
    applyStimulus(FLAG_TM, 1'b1, 1'b0);
    applyStimulus(8'h12, 1'b1, 1'b0);
    applyStimulus(8'h34, 1'b1, 1'b0);
    expectCmd(FLAG_TM, 16'h1234);
    applyStimulus(FLAG_TM + 8'h46, 1'b1, 1'b0);
    checkOutput("tm_payload", bus.payload, 16'h1234);
    checkOutput("tm_busy_after", 16'(bus.busy), 16'd0);
    repeat (2) @(negedge clk);

    $display("[TB] checksum wrap, back-to-back with bad checksum");
    sendMsg(FLAG_DPR, 8'hFF, 8'hFF, 8'h00);
    sendMsg(FLAG_DPR, 8'hFF, 8'hFF, 8'h01);
    checkOutput("wrap_payload_kept", bus.payload, 16'hFFFF);
    checkOutput("csum_err_code", 16'(bus.err_code), 16'd2);
    repeat (2) @(negedge clk);

    $display("[TB] marker resync and undefined flag");
    applyStimulus(MARKER, 1'b1, 1'b0);
    sendMsg(FLAG_SR, 8'h5A, 8'hC3, 8'h00);
    applyStimulus(MARKER, 1'b1, 1'b0);
    expectErr(2'd1);
    applyStimulus(8'h77, 1'b1, 1'b0);
    checkOutput("badflag_busy", 16'(bus.busy), 16'd0);
    repeat (2) @(negedge clk);

    $display("[TB] inter-byte timeout");
    applyStimulus(MARKER, 1'b1, 1'b0);
    applyStimulus(FLAG_SR, 1'b1, 1'b0);
    expectErr(2'd3);
    applyStimulus(8'hAA, 1'b1, 1'b0);
    repeat (TIMEOUT - 1) @(negedge clk);
    checkOutput("timeout_not_early", 16'(bus.busy), 16'd1);
    @(negedge clk);
    checkOutput("timeout_busy", 16'(bus.busy), 16'd0);
    checkOutput("timeout_code", 16'(bus.err_code), 16'd3);
    sendMsg(FLAG_SR, 8'h0F, 8'hF0, 8'h00);
    repeat (2) @(negedge clk);

    $display("[TB] decoder error with PL_LO byte, then in IDLE");
    applyStimulus(MARKER, 1'b1, 1'b0);
    applyStimulus(FLAG_TM, 1'b1, 1'b0);
    applyStimulus(8'h11, 1'b1, 1'b0);
    expectErr(2'd3);
    applyStimulus(8'h22, 1'b1, 1'b1);
    checkOutput("derr_busy", 16'(bus.busy), 16'd0);
    applyStimulus(8'h00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("derr_idle_code_held", 16'(bus.err_code), 16'd3);

    $display("[TB] reset mid-message");
    applyStimulus(MARKER, 1'b1, 1'b0);
    applyStimulus(FLAG_DPR, 1'b1, 1'b0);
    applyStimulus(8'h99, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 16'(bus.busy), 16'd0);
    checkOutput("midreset_payload", bus.payload, 16'h0000);
    model_payload = 16'h0000;
    model_code = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sendMsg(FLAG_DPR, 8'hAB, 8'hCD, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("post_reset_payload", bus.payload, 16'hABCD);

    checkOutput("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tm_sr_dpr_rcv.md
# tm_sr_dpr_rcv

Slave-side receiver for the master command messages (time mark, status request, data packet request). It sits behind the byte decoder on the slave end of the link and consumes one decoded byte per `d_rdy` strobe. It frames the 5-byte message (marker, flag, two payload bytes, checksum), validates it, and issues a one-cycle command pulse with the latched payload. Malformed or stalled messages are reported through `msg_err`/`err_code`.

## Interface
Parameters:
- `MARKER`, default `MARKER_MASTER` from `msg_defs.vh`: start-of-message byte.
- `FLAG_TM`, default `FLAG_TIME_MARK`: flag byte for a time mark.
- `FLAG_SR`, default `FLAG_STATUS_REQUEST`: flag byte for a status request.
- `FLAG_DPR`, default `FLAG_DATA_PACKET_REQUEST`: flag byte for a data packet request.
- `TIMEOUT`, default 1024: maximum number of clk cycles allowed between bytes inside a message; range 2..65535.

Ports:
- `clk` in 1: single clock domain; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `d` in 8: decoded byte; valid only while `d_rdy`=1.
- `d_rdy` in 1: one-cycle strobe, one strobe per received byte.
- `d_err` in 1: one-cycle decoder error strobe (code violation or parity).
- `tm_rcvd` out 1: one-cycle pulse on a valid time mark.
- `sr_rcvd` out 1: one-cycle pulse on a valid status request.
- `dpr_rcvd` out 1: one-cycle pulse on a valid data packet request.
- `payload` out 16: {byte2, byte3} of the last valid message.
- `msg_err` out 1: one-cycle pulse on an aborted message.
- `err_code` out 2: cause of the last error; 1 = bad flag, 2 = checksum, 3 = timeout or decoder error. Held until the next error.
- `busy` out 1: high while a message is being collected (FSM not in IDLE).

## Operation
- FSM states and transitions, each taken only on `d_rdy`:
  - IDLE → FLAG when `d`==MARKER. Any other byte is discarded silently.
  - FLAG → PL_HI when `d` is one of the three flags; the flag is stored.
  - FLAG stays in FLAG when `d`==MARKER (resync); no error is raised.
  - FLAG → IDLE on any other value, with `msg_err` and err_code=1.
  - PL_HI → PL_LO; PL_HI stores `d` in a shadow high byte.
  - PL_LO → CSUM; PL_LO stores `d` in a shadow low byte.
  - CSUM → IDLE in all cases.
- Checksum: `d` in CSUM must equal (flag + byte2 + byte3) mod 256, computed with an 8-bit wraparound adder.
  - Match: `payload` is loaded from the shadow bytes and exactly one of tm/sr/dpr_rcvd pulses, selected by the stored flag.
  - Mismatch: `msg_err` pulses with err_code=2 and `payload` is unchanged.
- `d_err` while `busy`: abort to IDLE, `msg_err`, err_code=3. `d_err` in IDLE is ignored.
- Inter-byte timer:
  - Cleared on entering FLAG and on every `d_rdy`.
  - Increments each cycle while `busy`.
  - When it reaches TIMEOUT-1 with no `d_rdy`, the FSM aborts to IDLE with `msg_err` and err_code=3.
- Priority within one cycle: `d_err` > `d_rdy` > timeout. If `d_rdy` and `d_err` coincide, the byte is dropped and the message aborts.
- The shadow bytes never drive `payload` directly; `payload` changes only on a valid message.

## Timing
- Reset values: state IDLE, busy=0, tm/sr/dpr_rcvd=0, msg_err=0, err_code=0, payload=16'h0000, timer=0.
- Asserting `rst_n` mid-message returns the FSM to IDLE immediately and asynchronously, with no pulse.
- All outputs are registered.
- Command pulse and `msg_err` go high in the cycle after the edge that samples the deciding `d_rdy`. The new `payload` is visible in the same cycle as the command pulse.
- `busy` rises the cycle after the marker is sampled. It falls in the same cycle as the command pulse or `msg_err`.
- Back-to-back messages: a MARKER strobe in the cycle immediately after the CSUM byte is accepted. There is no dead cycle.
- `d_rdy` may arrive on consecutive cycles; the receiver accepts one byte per cycle.

## Test plan
- Valid TM: MARKER, FLAG_TM, 8'h12, 8'h34, (FLAG_TM+8'h46) mod 256 → one tm_rcvd pulse, payload=16'h1234, msg_err never high, busy low afterwards.
- Checksum wrap: FLAG_DPR message with bytes 8'hFF, 8'hFF and checksum (FLAG_DPR+8'hFE) mod 256 → dpr_rcvd pulse, payload=16'hFFFF. The same message with checksum+1 → msg_err, err_code=2, payload still 16'hFFFF.
- Framing:
  - Garbage 8'h00, 8'h55 before MARKER → ignored.
  - MARKER, MARKER, FLAG_SR, … → accepted as one SR message.
  - MARKER followed by an undefined flag → msg_err, err_code=2'd1.
- Timeout: MARKER, FLAG_SR, 8'hAA, then no strobe for TIMEOUT cycles → msg_err, err_code=3, busy=0. A following valid SR message → sr_rcvd.
- Simultaneous events: `d_err` together with the PL_LO `d_rdy` → abort with err_code=3. `d_err` alone in IDLE → no msg_err.
- Reset mid-message after byte 3: pull `rst_n` low → busy=0 at once, no pulses. A complete message after release → decoded correctly.
